// File: rtl/squash_pkg.sv
// Shared types and width helpers for the squash 5/3 lifting sequencer.
package squash_pkg;

  localparam int unsigned SQ_DATA_W  = 8;
  localparam int unsigned SQ_MAX_LEN = 16;
  localparam int unsigned SQ_ADDR_W  = 4;
  localparam int unsigned LIFT_RND   = 2;

  // Coefficient widths derived from the sample width.
  function automatic int unsigned sq_h_w(input int unsigned dw);
    return dw + 1;
  endfunction

  function automatic int unsigned sq_l_w(input int unsigned dw);
    return dw + 2;
  endfunction

  function automatic int unsigned sq_sum_w(input int unsigned dw);
    return dw + 3;
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRIME,
    ST_RD_ODD,
    ST_RD_EVEN,
    ST_CALC,
    ST_EMIT
  } sq_state_e;

endpackage

// File: rtl/squash_lift_pe.sv
// Combinational 5/3 lifting step: predict d[n], then update s[n] with floor rounding.
module squash_lift_pe
  import squash_pkg::*;
#(
  parameter  int unsigned DATA_W = SQ_DATA_W,
  localparam int unsigned H_W    = sq_h_w(DATA_W),
  localparam int unsigned L_W    = sq_l_w(DATA_W)
) (
  input  logic [DATA_W-1:0]     i_x_even,
  input  logic [DATA_W-1:0]     i_x_odd,
  input  logic [DATA_W-1:0]     i_x_next,
  input  logic signed [H_W-1:0] i_d_prev,
  input  logic                  i_first,
  output logic signed [H_W-1:0] o_d,
  output logic signed [L_W-1:0] o_s
);

  localparam int unsigned SUM_W = sq_sum_w(DATA_W);

  logic signed [SUM_W-1:0] w_xe;
  logic signed [SUM_W-1:0] w_xo;
  logic signed [SUM_W-1:0] w_xn;
  logic signed [SUM_W-1:0] w_d;
  logic signed [SUM_W-1:0] w_dp;
  logic signed [SUM_W-1:0] w_s;

  assign w_xe = $signed(SUM_W'(i_x_even));
  assign w_xo = $signed(SUM_W'(i_x_odd));
  assign w_xn = $signed(SUM_W'(i_x_next));

  assign w_d  = w_xo - ((w_xe + w_xn) >>> 1);
  // Left edge mirrors d[0] into d[-1].
  assign w_dp = i_first ? w_d : SUM_W'(i_d_prev);
  assign w_s  = w_xe + ((w_dp + w_d + $signed(SUM_W'(LIFT_RND))) >>> 2);

  assign o_d = H_W'(w_d);
  assign o_s = L_W'(w_s);

endmodule

// File: rtl/squash_lift_ctrl.sv
// Line sequencer for the 5/3 lifting transform: fetches even/odd samples,
// runs the lifting PE and hands out one H/L pair per handshake.
module squash_lift_ctrl
  import squash_pkg::*;
#(
  parameter  int unsigned DATA_W  = SQ_DATA_W,
  parameter  int unsigned MAX_LEN = SQ_MAX_LEN,
  parameter  int unsigned ADDR_W  = SQ_ADDR_W,
  localparam int unsigned H_W     = sq_h_w(DATA_W),
  localparam int unsigned L_W     = sq_l_w(DATA_W)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_W:0]       line_len,
  output logic                  mem_rd,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic [DATA_W-1:0]     mem_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic signed [H_W-1:0] out_h,
  output logic signed [L_W-1:0] out_l,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned LEN_W  = ADDR_W + 1;
  localparam int unsigned PAIR_W = ADDR_W - 1;

  sq_state_e               r_state;
  logic                    r_phase;
  logic [PAIR_W-1:0]       r_n;
  logic [PAIR_W-1:0]       r_last_n;
  logic [DATA_W-1:0]       r_x_even;
  logic [DATA_W-1:0]       r_x_odd;
  logic [DATA_W-1:0]       r_x_next;
  logic signed [H_W-1:0]   r_d_prev;
  logic                    r_mem_rd;
  logic [ADDR_W-1:0]       r_mem_addr;
  logic                    r_out_valid;
  logic signed [H_W-1:0]   r_out_h;
  logic signed [L_W-1:0]   r_out_l;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_err;

  logic                    w_len_ok;
  logic                    w_last;
  logic [PAIR_W-1:0]       w_n_inc;
  logic signed [H_W-1:0]   w_d;
  logic signed [L_W-1:0]   w_s;

  assign w_len_ok = !line_len[0] && (line_len >= LEN_W'(2)) && (line_len <= LEN_W'(MAX_LEN));
  assign w_last   = (r_n == r_last_n);
  assign w_n_inc  = r_n + PAIR_W'(1);

  squash_lift_pe #(.DATA_W(DATA_W)) u_pe (
    .i_x_even (r_x_even),
    .i_x_odd  (r_x_odd),
    .i_x_next (r_x_next),
    .i_d_prev (r_d_prev),
    .i_first  (r_n == '0),
    .o_d      (w_d),
    .o_s      (w_s)
  );

  // Read states alternate issue (phase 0) and capture (phase 1); the strobe
  // for the next read is raised on the transition that enters its state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_phase     <= 1'b0;
      r_n         <= '0;
      r_last_n    <= '0;
      r_x_even    <= '0;
      r_x_odd     <= '0;
      r_x_next    <= '0;
      r_d_prev    <= '0;
      r_mem_rd    <= 1'b0;
      r_mem_addr  <= '0;
      r_out_valid <= 1'b0;
      r_out_h     <= '0;
      r_out_l     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (w_len_ok) begin
              r_state    <= ST_PRIME;
              r_phase    <= 1'b0;
              r_n        <= '0;
              r_last_n   <= PAIR_W'(line_len[ADDR_W:1] - ADDR_W'(1));
              r_mem_rd   <= 1'b1;
              r_mem_addr <= '0;
              r_busy     <= 1'b1;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        ST_PRIME: begin
          if (!r_phase) begin
            r_phase  <= 1'b1;
            r_mem_rd <= 1'b0;
          end else begin
            r_x_even   <= mem_data;
            r_state    <= ST_RD_ODD;
            r_phase    <= 1'b0;
            r_mem_rd   <= 1'b1;
            r_mem_addr <= {r_n, 1'b1};
          end
        end
        ST_RD_ODD: begin
          if (!r_phase) begin
            r_phase  <= 1'b1;
            r_mem_rd <= 1'b0;
          end else begin
            r_x_odd <= mem_data;
            r_phase <= 1'b0;
            if (w_last) begin
              // Right edge: x[len] mirrors x[len-2], no fetch needed.
              r_x_next <= r_x_even;
              r_state  <= ST_CALC;
            end else begin
              r_state    <= ST_RD_EVEN;
              r_mem_rd   <= 1'b1;
              r_mem_addr <= {w_n_inc, 1'b0};
            end
          end
        end
        ST_RD_EVEN: begin
          if (!r_phase) begin
            r_phase  <= 1'b1;
            r_mem_rd <= 1'b0;
          end else begin
            r_x_next <= mem_data;
            r_phase  <= 1'b0;
            r_state  <= ST_CALC;
          end
        end
        ST_CALC: begin
          r_out_h     <= w_d;
          r_out_l     <= w_s;
          r_out_valid <= 1'b1;
          r_state     <= ST_EMIT;
        end
        ST_EMIT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_d_prev    <= r_out_h;
            r_x_even    <= r_x_next;
            if (w_last) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_n        <= w_n_inc;
              r_state    <= ST_RD_ODD;
              r_phase    <= 1'b0;
              r_mem_rd   <= 1'b1;
              r_mem_addr <= {w_n_inc, 1'b1};
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign mem_rd    = r_mem_rd;
  assign mem_addr  = r_mem_addr;
  assign out_valid = r_out_valid;
  assign out_h     = r_out_h;
  assign out_l     = r_out_l;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: tb/tb_squash_lift_ctrl.sv
// Directed bench for squash_lift_ctrl with a 1-cycle-latency line memory model.
module tb_squash_lift_ctrl;
  import squash_pkg::*;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned MAX_LEN = 16;
  localparam int unsigned ADDR_W  = 4;
  localparam int unsigned H_W     = DATA_W + 1;
  localparam int unsigned L_W     = DATA_W + 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  start;
  logic [ADDR_W:0]       line_len;
  logic                  mem_rd;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_data;
  logic                  out_valid;
  logic                  out_ready;
  logic signed [H_W-1:0] out_h;
  logic signed [L_W-1:0] out_l;
  logic                  busy;
  logic                  done;
  logic                  err;

  squash_lift_ctrl #(.DATA_W(DATA_W), .MAX_LEN(MAX_LEN), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .line_len  (line_len),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_h     (out_h),
    .out_l     (out_l),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] mem [0:MAX_LEN-1];
  always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];

  int rd_q[$];
  int n_done = 0;
  int n_err  = 0;
  int n_busy = 0;
  always @(negedge clk) begin
    if (mem_rd) rd_q.push_back(int'(mem_addr));
    if (done)   n_done++;
    if (err)    n_err++;
    if (busy)   n_busy++;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int res_h [0:7];
  int res_l [0:7];

  task automatic check_eq(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic load(input int a0, input int a1, input int a2, input int a3);
    for (int i = 0; i < int'(MAX_LEN); i++) mem[i] = 8'hEE;
    mem[0] = DATA_W'(a0);
    mem[1] = DATA_W'(a1);
    mem[2] = DATA_W'(a2);
    mem[3] = DATA_W'(a3);
  endtask

  // Runs one line; stalls the first EMIT for 'stall' cycles. first_valid is
  // the cycle index (cycle 1 follows the edge that samples start).
  task automatic run_line(input string tag, input int len, input int stall,
                          output int np, output int first_valid);
    int  k;
    int  stall_left;
    int  hold_h;
    int  hold_l;
    bit  got_done;
    np = 0;
    first_valid = -1;
    stall_left = stall;
    hold_h = 0;
    hold_l = 0;
    got_done = 1'b0;
    @(negedge clk);
    start = 1'b1;
    line_len = (ADDR_W+1)'(len);
    @(negedge clk);
    start = 1'b0;
    k = 1;
    while (!got_done && k < 200) begin
      if (done) got_done = 1'b1;
      if (out_valid) begin
        if (first_valid < 0) first_valid = k;
        if (np == 0 && stall_left > 0) begin
          if (stall_left == stall) begin
            hold_h = int'(out_h);
            hold_l = int'(out_l);
          end else begin
            check_eq({tag, "_stall_h"}, int'(out_h), hold_h);
            check_eq({tag, "_stall_l"}, int'(out_l), hold_l);
          end
          check_eq({tag, "_stall_rd"}, int'(mem_rd), 0);
          out_ready = 1'b0;
          stall_left--;
        end else begin
          if (np == 0 && stall > 0) check_eq({tag, "_stall_end_h"}, int'(out_h), hold_h);
          if (np < 8) begin
            res_h[np] = int'(out_h);
            res_l[np] = int'(out_l);
          end
          np++;
          out_ready = 1'b1;
        end
      end else begin
        out_ready = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    out_ready = 1'b0;
    check_eq({tag, "_done_seen"}, int'(got_done), 1);
  endtask

  task automatic verify_len4(input string tag, input int stall);
    int idx;
    int d0;
    int np;
    int fv;
    load(22, 44, 50, 70);
    idx = rd_q.size();
    d0 = n_done;
    run_line(tag, 4, stall, np, fv);
    repeat (3) @(negedge clk);
    check_eq({tag, "_npairs"}, np, 2);
    check_eq({tag, "_h0"}, res_h[0], 8);
    check_eq({tag, "_l0"}, res_l[0], 26);
    check_eq({tag, "_h1"}, res_h[1], 20);
    check_eq({tag, "_l1"}, res_l[1], 57);
    check_eq({tag, "_first_valid"}, fv, 8);
    check_eq({tag, "_done_cnt"}, n_done - d0, 1);
    check_eq({tag, "_rd_cnt"}, rd_q.size() - idx, 4);
    for (int i = 0; i < 4; i++)
      if (idx + i < rd_q.size()) check_eq({tag, "_rd_addr"}, rd_q[idx+i], i);
    check_eq({tag, "_busy_end"}, int'(busy), 0);
  endtask

  task automatic verify_len2(input string tag, input int a0, input int a1,
                             input int exp_h, input int exp_l);
    int idx;
    int np;
    int fv;
    load(a0, a1, 8'hEE, 8'hEE);
    idx = rd_q.size();
    run_line(tag, 2, 0, np, fv);
    repeat (2) @(negedge clk);
    check_eq({tag, "_npairs"}, np, 1);
    check_eq({tag, "_h"}, res_h[0], exp_h);
    check_eq({tag, "_l"}, res_l[0], exp_l);
    check_eq({tag, "_first_valid"}, fv, 6);
    check_eq({tag, "_rd_cnt"}, rd_q.size() - idx, 2);
    for (int i = 0; i < 2; i++)
      if (idx + i < rd_q.size()) check_eq({tag, "_rd_addr"}, rd_q[idx+i], i);
  endtask

  task automatic bad_start(input string tag, input int len);
    int idx;
    int e0;
    int b0;
    idx = rd_q.size();
    e0 = n_err;
    b0 = n_busy;
    @(negedge clk);
    start = 1'b1;
    line_len = (ADDR_W+1)'(len);
    @(negedge clk);
    start = 1'b0;
    check_eq({tag, "_err_pulse"}, int'(err), 1);
    @(negedge clk);
    check_eq({tag, "_err_clear"}, int'(err), 0);
    repeat (4) @(negedge clk);
    check_eq({tag, "_err_cnt"}, n_err - e0, 1);
    check_eq({tag, "_no_rd"}, rd_q.size() - idx, 0);
    check_eq({tag, "_no_busy"}, n_busy - b0, 0);
  endtask

  task automatic abort_line();
    int k;
    int d0;
    load(22, 44, 50, 70);
    d0 = n_done;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b1;
    line_len = (ADDR_W+1)'(4);
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!(mem_rd && mem_addr == ADDR_W'(3)) && k < 50) begin
      @(negedge clk);
      k++;
    end
    check_eq("abort_reach_odd2", int'(k < 50), 1);
    #1 rst_n = 1'b0;
    #1;
    check_eq("abort_valid", int'(out_valid), 0);
    check_eq("abort_rd", int'(mem_rd), 0);
    check_eq("abort_addr", int'(mem_addr), 0);
    check_eq("abort_busy", int'(busy), 0);
    check_eq("abort_h", int'(out_h), 0);
    check_eq("abort_l", int'(out_l), 0);
    out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("abort_no_done", n_done - d0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    line_len = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_valid", int'(out_valid), 0);
    check_eq("rst_rd", int'(mem_rd), 0);
    check_eq("rst_addr", int'(mem_addr), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_done", int'(done), 0);
    check_eq("rst_err", int'(err), 0);
    check_eq("rst_h", int'(out_h), 0);
    check_eq("rst_l", int'(out_l), 0);
    rst_n = 1'b1;
    @(negedge clk);

    verify_len4("len4", 0);
    verify_len2("len2", 10, 30, 20, 20);
    verify_len2("len2_neg", 200, 0, -200, 100);
    verify_len4("len4_stall", 5);
    bad_start("bad5", 5);
    bad_start("bad0", 0);
    bad_start("bad18", 18);
    abort_line();
    verify_len4("len4_after_abort", 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
